// File: rtl/pipeline_result_checker_pkg.sv
// Shared widths and FSM encoding for the pipeline result checker.
package pipeline_result_checker_pkg;
    localparam int PC_W  = 64;
    localparam int IDX_W = 3;
    localparam int WD_W  = 16;
    localparam int DLY_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4,
        S_TMO     = 3'd5
    } state_t;
endpackage

// File: rtl/pipeline_result_checker_watchdog.sv
// 16-bit saturating watchdog; expired is a level once the count reaches the limit.
module watchdog_counter
    import pipeline_result_checker_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [WD_W-1:0] i_limit,
    output logic            o_expired
);
    logic [WD_W-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Rst || i_clear)
            r_count <= '0;
        else if (i_enable && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_expired = (r_count >= i_limit);
endmodule

// File: rtl/pipeline_result_checker.sv
// On-chip program check monitor: waits for each milestone PC, lets writeback settle, compares dMemOut.
module pipeline_result_checker
    import pipeline_result_checker_pkg::*;
#(
    parameter int                         NUM_CHECKS    = 2,
    parameter int                         WB_DELAY      = 4,
    parameter logic [WD_W-1:0]            TIMEOUT       = 16'hFFFF,
    parameter logic [NUM_CHECKS*64-1:0]   MILESTONE_PCS = {64'h100, 64'h058},
    parameter logic [NUM_CHECKS*64-1:0]   EXPECTED_VALS = {64'h123456789abcdef0, 64'hF}
)(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [PC_W-1:0]       FetchedPC,
    input  logic [PC_W-1:0]       dMemOut,
    output logic                  CheckValid,
    output logic [IDX_W-1:0]      CheckIdx,
    output logic                  CheckPass,
    output logic [7:0]            PassCount,
    output logic [NUM_CHECKS-1:0] FailMask,
    output logic                  Done,
    output logic                  AllPassed,
    output logic                  Timeout
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(WB_DELAY - 1);

    state_t                r_state, w_next;
    logic [IDX_W-1:0]      r_idx;
    logic [DLY_W-1:0]      r_dly;
    logic                  r_valid, r_chk_pass, r_done, r_allp, r_tmo;
    logic [IDX_W-1:0]      r_chk_idx;
    logic [7:0]            r_pass_cnt;
    logic [NUM_CHECKS-1:0] r_fail;

    logic [PC_W-1:0]       w_milestone, w_expected;
    logic [NUM_CHECKS-1:0] w_onehot;
    logic                  w_hit, w_last, w_pass, w_wd_exp;
    logic                  w_arm, w_cmp, w_wd_en, w_enter_dly, w_to_tmo;
    logic [7:0]            w_pass_next;

    always_comb begin
        w_milestone = MILESTONE_PCS[PC_W-1:0];
        w_expected  = EXPECTED_VALS[PC_W-1:0];
        w_onehot    = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_milestone = MILESTONE_PCS[i*PC_W +: PC_W];
                w_expected  = EXPECTED_VALS[i*PC_W +: PC_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Level compare: a PC that later branches back cannot un-hit the milestone.
    assign w_hit       = (FetchedPC >= w_milestone);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_pass      = (dMemOut == w_expected);
    assign w_pass_next = r_pass_cnt + {7'd0, w_pass};

    watchdog_counter u_wd (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_clear   (w_arm),
        .i_enable  (w_wd_en),
        .i_limit   (TIMEOUT),
        .o_expired (w_wd_exp)
    );

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TMO: if (Start) w_next = S_ARMED;
            S_ARMED: begin
                if (w_wd_exp)   w_next = S_TMO;
                else if (w_hit) w_next = S_DELAY;
            end
            S_DELAY: begin
                if (w_wd_exp)               w_next = S_TMO;
                else if (r_dly == DLY_LAST) w_next = S_COMPARE;
            end
            // The compare in flight is always reported; completing the last one beats the watchdog.
            S_COMPARE: begin
                if (w_last)        w_next = S_DONE;
                else if (w_wd_exp) w_next = S_TMO;
                else               w_next = S_ARMED;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_arm   = 1'b0;
        w_cmp   = 1'b0;
        w_wd_en = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_TMO: w_arm = Start;
            S_ARMED, S_DELAY:      w_wd_en = 1'b1;
            S_COMPARE: begin
                w_wd_en = 1'b1;
                w_cmp   = 1'b1;
            end
            default: ;
        endcase
        w_enter_dly = (r_state == S_ARMED) && (w_next == S_DELAY);
        w_to_tmo    = (r_state != S_TMO) && (w_next == S_TMO);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_idx      <= '0;
            r_dly      <= '0;
            r_valid    <= 1'b0;
            r_chk_idx  <= '0;
            r_chk_pass <= 1'b0;
            r_pass_cnt <= '0;
            r_fail     <= '0;
            r_done     <= 1'b0;
            r_allp     <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_valid <= w_cmp;
            if (w_arm) begin
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_fail     <= '0;
                r_done     <= 1'b0;
                r_allp     <= 1'b0;
                r_tmo      <= 1'b0;
            end
            if (w_enter_dly)
                r_dly <= '0;
            else if (r_state == S_DELAY)
                r_dly <= r_dly + 1'b1;
            if (w_cmp) begin
                r_chk_idx  <= r_idx;
                r_chk_pass <= w_pass;
                r_pass_cnt <= w_pass_next;
                if (!w_pass) r_fail <= r_fail | w_onehot;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_allp <= (w_pass_next == 8'(NUM_CHECKS));
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_to_tmo) begin
                r_tmo  <= 1'b1;
                r_done <= 1'b0;
            end
        end
    end

    assign CheckValid = r_valid;
    assign CheckIdx   = r_chk_idx;
    assign CheckPass  = r_chk_pass;
    assign PassCount  = r_pass_cnt;
    assign FailMask   = r_fail;
    assign Done       = r_done;
    assign AllPassed  = r_allp;
    assign Timeout    = r_tmo;
endmodule
